// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal CMP core pipeline: default widths,
// the NOP encoding used for flush bubbles, and the skid-stage state encoding.
package cardinal_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'hF000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by perf counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear)             count <= '0;
    else if (en && (count != '1))   count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer, registered
// in_ready, flush-to-bubble and a saturating back-pressure counter.
module pipe_skid_stage
  import cardinal_pkg::*;
#(
  parameter int          DATA_W       = DATA_W_DEF,
  parameter int          PC_W         = PC_W_DEF,
  parameter logic [31:0] NOP_INST     = NOP_INST_DEF,
  parameter bit          FLUSH_BUBBLE = 1'b1,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] in_inst,
  input  logic [0:PC_W-1]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_inst,
  output logic [0:PC_W-1]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [0:DATA_W-1] NOP_W = DATA_W'(NOP_INST);

  stage_state_t      state, state_nxt;
  logic [0:DATA_W-1] main_inst, main_inst_nxt, skid_inst, skid_inst_nxt;
  logic [0:PC_W-1]   main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
  logic              rdy_q, in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = rdy_q;
  assign out_inst  = main_inst;
  assign out_pc    = main_pc;
  assign in_fire   = in_valid & rdy_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt     = state;
    main_inst_nxt = main_inst;
    main_pc_nxt   = main_pc;
    skid_inst_nxt = skid_inst;
    skid_pc_nxt   = skid_pc;
    if (flush) begin
      skid_inst_nxt = '0;
      skid_pc_nxt   = '0;
      main_pc_nxt   = '0;
      if (FLUSH_BUBBLE) begin
        state_nxt     = ONE;
        main_inst_nxt = NOP_W;
      end else begin
        state_nxt     = EMPTY;
        main_inst_nxt = '0;
      end
    end else begin
      unique case (state)
        EMPTY: if (in_fire) begin
          state_nxt     = ONE;
          main_inst_nxt = in_inst;
          main_pc_nxt   = in_pc;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_inst_nxt = in_inst;
            main_pc_nxt   = in_pc;
          end else if (in_fire) begin
            state_nxt     = TWO;
            skid_inst_nxt = in_inst;
            skid_pc_nxt   = in_pc;
          end else if (out_fire) begin
            state_nxt     = EMPTY;
          end
        end
        // in_ready is low here, so only the drain path exists
        TWO: if (out_fire) begin
          state_nxt     = ONE;
          main_inst_nxt = skid_inst;
          main_pc_nxt   = skid_pc;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_inst <= '0;
      main_pc   <= '0;
      skid_inst <= '0;
      skid_pc   <= '0;
      rdy_q     <= 1'b1;
    end else begin
      state     <= state_nxt;
      main_inst <= main_inst_nxt;
      main_pc   <= main_pc_nxt;
      skid_inst <= skid_inst_nxt;
      skid_pc   <= skid_pc_nxt;
      rdy_q     <= (state_nxt != TWO);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three instances (default, no-bubble, 4-bit counter)
// share stimulus and are each compared every cycle against a 2-slot FIFO model.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        a_v, a_rdy, b_v, b_rdy, c_v, c_rdy;
  logic [31:0] a_inst, a_pc, b_inst, b_pc, c_inst, c_pc;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_skid_stage dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_v), .out_ready(out_ready),
    .out_inst(a_inst), .out_pc(a_pc), .stall_cnt(a_cnt));

  pipe_skid_stage #(.FLUSH_BUBBLE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_v), .out_ready(out_ready),
    .out_inst(b_inst), .out_pc(b_pc), .stall_cnt(b_cnt));

  pipe_skid_stage #(.CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(c_v), .out_ready(out_ready),
    .out_inst(c_inst), .out_pc(c_pc), .stall_cnt(c_cnt));

  // Reference model: a FIFO of at most two entries per instance
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        sl [3][2];
  int          n   [3];
  logic [31:0] li  [3];
  logic [31:0] lp  [3];
  int unsigned cnt [3];
  bit          bub [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned cmax[3] = '{65535, 65535, 15};

  task automatic model_step(input int m);
    bit inf, outf;
    if (reset) begin
      n[m] = 0; li[m] = 0; lp[m] = 0; cnt[m] = 0;
      return;
    end
    if (n[m] > 0 && !out_ready && cnt[m] < cmax[m]) cnt[m]++;
    if (flush) begin
      if (bub[m]) begin
        n[m] = 1; sl[m][0].inst = 32'hF000_0000; sl[m][0].pc = 0;
      end else begin
        n[m] = 0; li[m] = 0; lp[m] = 0;
      end
    end else begin
      inf  = in_valid && (n[m] < 2);
      outf = (n[m] > 0) && out_ready;
      if (outf) begin sl[m][0] = sl[m][1]; n[m]--; end
      if (inf) begin sl[m][n[m]].inst = in_inst; sl[m][n[m]].pc = in_pc; n[m]++; end
    end
    if (n[m] > 0) begin li[m] = sl[m][0].inst; lp[m] = sl[m][0].pc; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_m(input int m, input string tag, input logic v, input logic rdy,
                       input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] c);
    chk({tag, ".out_valid"}, 32'(v),   32'(n[m] > 0));
    chk({tag, ".in_ready"},  32'(rdy), 32'(n[m] < 2));
    chk({tag, ".out_inst"},  inst,     li[m]);
    chk({tag, ".out_pc"},    pc,       lp[m]);
    chk({tag, ".stall_cnt"}, c,        cnt[m]);
  endtask

  task automatic tick();
    for (int m = 0; m < 3; m++) model_step(m);
    @(posedge clk);
    #1;
    chk_m(0, "a", a_v, a_rdy, a_inst, a_pc, 32'(a_cnt));
    chk_m(1, "b", b_v, b_rdy, b_inst, b_pc, 32'(b_cnt));
    chk_m(2, "c", c_v, c_rdy, c_inst, c_pc, 32'(c_cnt));
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] inst, input logic [31:0] pc);
    reset = r; flush = f; in_valid = iv; out_ready = ordy; in_inst = inst; in_pc = pc;
  endtask

  typedef struct {
    logic rst, fl, iv, ordy;
    logic [31:0] inst, pc;
    logic ev, erdy;
    logic [31:0] einst, epc;
    logic [15:0] ecnt;
  } vec_t;

  localparam logic [31:0] NOP = 32'hF000_0000;
  localparam logic [31:0] A   = 32'hA000_0000;

  vec_t tbl[18];

  initial begin
    // Directed sequence with hand-computed expectations for the default instance
    //          rst   fl    iv    ordy  inst          pc         ev    erdy  einst         epc        ecnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0,            0,         1'b0, 1'b1, 0,            0,         0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0000,32'h100,   1'b1, 1'b1, 32'h1111_0000,32'h100,   0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,            0,         1'b0, 1'b1, 32'h1111_0000,32'h100,   0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, A+32'h0,      32'h0,     1'b1, 1'b1, A+32'h0,      32'h0,     0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, A+32'h4,      32'h4,     1'b1, 1'b0, A+32'h0,      32'h0,     1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, A+32'h8,      32'h8,     1'b1, 1'b0, A+32'h0,      32'h0,     2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, A+32'h8,      32'h8,     1'b1, 1'b0, A+32'h0,      32'h0,     3};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, A+32'h8,      32'h8,     1'b1, 1'b1, A+32'h4,      32'h4,     3};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, A+32'h8,      32'h8,     1'b1, 1'b1, A+32'h8,      32'h8,     3};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, A+32'hC,      32'hC,     1'b1, 1'b1, A+32'hC,      32'hC,     3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,            0,         1'b0, 1'b1, A+32'hC,      32'hC,     3};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, A+32'h20,     32'h20,    1'b1, 1'b1, A+32'h20,     32'h20,    3};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, A+32'h24,     32'h24,    1'b1, 1'b0, A+32'h20,     32'h20,    4};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, A+32'h40,     32'h40,    1'b1, 1'b1, NOP,          0,         5};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,            0,         1'b0, 1'b1, NOP,          0,         5};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, A+32'h50,     32'h50,    1'b1, 1'b1, A+32'h50,     32'h50,    5};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, A+32'h54,     32'h54,    1'b1, 1'b1, NOP,          0,         6};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, A+32'h58,     32'h58,    1'b0, 1'b1, 0,            0,         0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int m = 0; m < 3; m++) begin n[m] = 0; li[m] = 0; lp[m] = 0; cnt[m] = 0; end

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].inst, tbl[i].pc);
      tick();
      chk($sformatf("tbl%0d.out_valid", i), 32'(a_v),   32'(tbl[i].ev));
      chk($sformatf("tbl%0d.in_ready", i),  32'(a_rdy), 32'(tbl[i].erdy));
      chk($sformatf("tbl%0d.out_inst", i),  a_inst,     tbl[i].einst);
      chk($sformatf("tbl%0d.out_pc", i),    a_pc,       tbl[i].epc);
      chk($sformatf("tbl%0d.stall_cnt", i), 32'(a_cnt), 32'(tbl[i].ecnt));
      if (i == 13) chk("tbl13.nobubble_valid", 32'(b_v), 32'(0));
    end

    // Counter saturation on the 4-bit instance; flush must not clear it
    drive(1'b0, 1'b0, 1'b1, 1'b0, A+32'h60, 32'h60);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat.c_cnt", 32'(c_cnt), 32'd15);
    chk("sat.a_cnt", 32'(a_cnt), 32'd20);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    tick();
    chk("sat_flush.c_cnt", 32'(c_cnt), 32'd15);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    chk("sat_reset.c_cnt", 32'(c_cnt), 32'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 500) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, $urandom, 32'(i) << 2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline register for inter-stage boundaries (IF/ID, ID/EX, ...) of the cardinal CMP core.
- Replaces the bare stall/flush register with a valid/ready handshake and a 2-entry skid buffer, so the upstream stage can see a registered ready without a combinational stall path.
- Flush injects a configurable NOP bubble.
- A saturating back-pressure counter is provided for performance monitoring.

Parameters:
- DATA_W, 32, instruction/payload width; bits indexed [0:DATA_W-1], bit 0 = MSB.
- PC_W, 32, PC width; indexed [0:PC_W-1].
- NOP_INST, 32'hF000_0000, instruction word loaded on flush; truncated/zero-extended to DATA_W.
- FLUSH_BUBBLE, 1, 1: flush produces a valid NOP entry; 0: flush leaves the stage empty.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset; clock clk
- flush  input  1  discard all held and incoming entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept (registered)
- in_inst  input  DATA_W  upstream instruction
- in_pc  input  PC_W  upstream PC
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_inst  output  DATA_W  output instruction
- out_pc  output  PC_W  output PC
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives out_*) plus one skid entry.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (main invalid), ONE (main valid, skid empty), TWO (both valid).
- in_ready = !skid_valid, taken from a register. It is 1 in EMPTY and ONE, and 0 in TWO.
- Transitions (no flush/reset):
  - EMPTY, in_fire -> ONE; main <= input.
  - ONE, in_fire & out_fire -> ONE; main <= input.
  - ONE, in_fire & !out_fire -> TWO; skid <= input.
  - ONE, !in_fire & out_fire -> EMPTY.
  - TWO, out_fire -> ONE; main <= skid. No input is accepted because in_ready=0.
  - All other cases hold state.
- Latency: 1 cycle from in_fire to out_valid when not back-pressured. Full throughput is 1 entry/cycle while out_ready=1.
- Ordering is strict FIFO. No entry is dropped or duplicated outside flush.
- While out_valid=1 and out_ready=0, out_inst/out_pc remain stable.
- Flush (registered, takes effect on the next edge):
  - Both entries are cleared. Any in_fire in the same cycle is discarded.
  - If FLUSH_BUBBLE=1: state becomes ONE with out_inst=NOP_INST and out_pc=0.
  - If FLUSH_BUBBLE=0: state becomes EMPTY with out_inst=0 and out_pc=0.
  - in_ready=1 after the edge.
  - A bubble is an ordinary entry: it holds under back-pressure and is consumed by out_fire.
- Priority: reset > flush > handshake.
- Reset values:
  - out_valid=0, out_inst=0, out_pc=0.
  - Skid entry invalid, skid data 0.
  - in_ready=1, stall_cnt=0, state EMPTY.
- Reset mid-operation drops all entries; no partial state survives.
- stall_cnt increments each cycle that out_valid & !out_ready holds.
  - It saturates at 2^CNT_W-1.
  - It is cleared only by reset; flush does not clear it.
- When the stage is empty, out_inst/out_pc hold their last values. Consumers must qualify them with out_valid.

Decomposition:
- Shared package cardinal_pkg:
  - NOP encoding constant (32'hF000_0000).
  - Default DATA_W/PC_W localparams.
  - State enum {EMPTY, ONE, TWO}.
- Natural sub-module: sat_counter (CNT_W, enable, synchronous clear, saturate). It is reused by other perf counters.

Test Plan:
- Reset, then in_valid=1 with inst 0x1111_0000 and pc 0x100, out_ready=1 -> next cycle out_valid=1, out_inst=0x1111_0000, out_pc=0x100, in_ready=1, stall_cnt=0.
- Stream 4 entries (pc 0x0, 0x4, 0x8, 0xC), out_ready=0 from cycle 2 -> in_ready drops after the 2nd entry; pc 0x0 holds on out; the 3rd entry waits upstream; stall_cnt counts up. Release out_ready -> outputs 0x0, 0x4, 0x8, 0xC in order with none lost.
- State TWO, flush=1 together with in_valid=1 (pc 0x40) -> next cycle out_valid=1, out_inst=0xF000_0000, out_pc=0, in_ready=1; pc 0x40 is never output. With FLUSH_BUBBLE=0 -> out_valid=0.
- reset and flush asserted together in state ONE -> out_valid=0, out_inst=0, in_ready=1, stall_cnt=0.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Flush does not change it; a later reset clears it to 0.
- Random in_valid/out_ready, 10k cycles -> scoreboard shows in-order delivery, out_* stable while stalled, and in_ready=0 only in state TWO.
